// File: rtl/seqdet_pkg.sv
// Shared constants and helpers for the programmable serial sequence detector.
// Output modes, default reset pattern and the state-width helper live here.
package seqdet_pkg;

    localparam int         MODE_MEALY  = 0;
    localparam int         MODE_MOORE  = 1;
    localparam logic [2:0] DEF_PATTERN = 3'b101;

    function automatic int state_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seqdet_prefix_match.sv
// Combinational suffix/prefix matcher: longest pattern prefix ending the candidate stream
// (valid history bits followed by the incoming bit), plus the overlap fallback length.
module seqdet_prefix_match
    import seqdet_pkg::*;
#(
    parameter  int PAT_W = 3,
    localparam int SW    = state_w(PAT_W)
) (
    input  logic [PAT_W-2:0] i_hist,
    input  logic [SW-1:0]    i_fill,
    input  logic             i_bit,
    input  logic [PAT_W-1:0] i_pattern,
    input  logic [SW-1:0]    i_state,
    output logic [SW-1:0]    o_nxt,
    output logic [SW-1:0]    o_fallback
);

    logic [PAT_W-1:0] w_window;
    int               w_lim;
    logic             w_eq;

    // Scan every length; the last qualifying length wins, so the result is the longest match.
    always_comb begin
        w_window   = {i_hist, i_bit};
        w_lim      = int'(i_state) + 1;
        w_lim      = ((int'(i_fill) + 1) < w_lim) ? (int'(i_fill) + 1) : w_lim;
        o_nxt      = '0;
        o_fallback = '0;
        w_eq       = 1'b0;
        for (int k = 1; k <= PAT_W; k++) begin
            w_eq = (k <= w_lim);
            for (int i = 0; i < k; i++) begin
                w_eq = w_eq & (i_pattern[PAT_W-1-i] == w_window[k-1-i]);
            end
            o_nxt      = w_eq ? SW'(k) : o_nxt;
            o_fallback = (w_eq && (k < PAT_W)) ? SW'(k) : o_fallback;
        end
    end

endmodule

// File: rtl/seqdet_prog_mealy_moore.sv
// Runtime-programmable serial sequence detector with selectable Mealy/Moore output.
// Optional match counter is built only when SEQDET_MATCH_COUNT_EN is defined.
module seqdet_prog_mealy_moore
    import seqdet_pkg::*;
#(
    parameter  int               PAT_W   = 3,
    parameter  logic [PAT_W-1:0] PAT_RST = PAT_W'(DEF_PATTERN),
    parameter  bit               OVL_RST = 1'b1,
    parameter  int               MOORE   = MODE_MEALY,
    parameter  int               CNT_W   = 8,
    localparam int               SW      = state_w(PAT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    output logic [SW-1:0]    state,
    output logic             match
`ifdef SEQDET_MATCH_COUNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt
`endif
);

    logic [PAT_W-1:0] r_pattern;
    logic [PAT_W-1:0] w_pattern_nxt;
    logic             r_ovl;
    logic             w_ovl_nxt;
    logic [PAT_W-2:0] r_hist;
    logic [PAT_W-2:0] w_hist_nxt;
    logic [SW-1:0]    r_fill;
    logic [SW-1:0]    w_fill_nxt;
    logic [SW-1:0]    r_state;
    logic [SW-1:0]    w_state_nxt;
    logic [SW-1:0]    w_nxt;
    logic [SW-1:0]    w_fallback;
    logic             w_accept;
    logic             w_hit;

    seqdet_prefix_match #(
        .PAT_W (PAT_W)
    ) u_prefix_match (
        .i_hist     (r_hist),
        .i_fill     (r_fill),
        .i_bit      (in_bit),
        .i_pattern  (r_pattern),
        .i_state    (r_state),
        .o_nxt      (w_nxt),
        .o_fallback (w_fallback)
    );

    // A configuration write discards any concurrent bit.
    assign w_accept = in_valid & ~cfg_we;
    assign w_hit    = w_accept & (w_nxt == SW'(PAT_W));

    // Next-state logic: reconfiguration, bit acceptance with overlap handling, or hold.
    always_comb begin
        w_pattern_nxt = r_pattern;
        w_ovl_nxt     = r_ovl;
        w_hist_nxt    = r_hist;
        w_fill_nxt    = r_fill;
        w_state_nxt   = r_state;
        if (cfg_we) begin
            w_pattern_nxt = cfg_pattern;
            w_ovl_nxt     = cfg_overlap;
            w_state_nxt   = '0;
            w_fill_nxt    = '0;
        end else if (in_valid) begin
            w_hist_nxt = (PAT_W-1)'({r_hist, in_bit});
            w_fill_nxt = (r_fill == SW'(PAT_W - 1)) ? r_fill : (r_fill + SW'(1));
            if (!w_hit) begin
                w_state_nxt = w_nxt;
            end else if (r_ovl) begin
                w_state_nxt = w_fallback;
            end else begin
                // Non-overlapping: nothing up to and including the match may seed the next one.
                w_state_nxt = '0;
                w_fill_nxt  = '0;
            end
        end else begin
            w_state_nxt = r_state;
        end
    end

    // State, history and configuration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pattern <= PAT_RST;
            r_ovl     <= OVL_RST;
            r_hist    <= '0;
            r_fill    <= '0;
            r_state   <= '0;
        end else begin
            r_pattern <= w_pattern_nxt;
            r_ovl     <= w_ovl_nxt;
            r_hist    <= w_hist_nxt;
            r_fill    <= w_fill_nxt;
            r_state   <= w_state_nxt;
        end
    end

    assign state = r_state;

    generate
        if (MOORE == MODE_MOORE) begin : g_moore
            logic r_match;

            // Moore output: the hit is presented in the cycle after the final bit.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_match <= 1'b0;
                end else begin
                    r_match <= w_hit;
                end
            end

            assign match = r_match;
        end else begin : g_mealy
            assign match = w_hit;
        end
    endgenerate

`ifdef SEQDET_MATCH_COUNT_EN
    logic [CNT_W-1:0] r_cnt;

    // Saturating hit counter, cleared by reconfiguration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (cfg_we) begin
            r_cnt <= '0;
        end else if (w_hit && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign match_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_seqdet_prog_mealy_moore.sv
// Scoreboard bench: Mealy and Moore 3-bit detectors share one stream, a 4-bit detector
// exercises all-ones overlap, non-overlap and counter saturation.
module tb_seqdet_prog_mealy_moore;

    typedef struct {
        logic m;
        int   s;
        int   c;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_bit;
    logic       cfg_we_a;
    logic [2:0] cfg_pattern_a;
    logic       cfg_overlap_a;
    logic       cfg_we_w;
    logic [3:0] cfg_pattern_w;
    logic       cfg_overlap_w;
    logic [1:0] state_a;
    logic [1:0] state_m;
    logic [2:0] state_w;
    logic       match_a;
    logic       match_m;
    logic       match_w;
`ifdef SEQDET_MATCH_COUNT_EN
    logic [1:0] cnt_a;
    logic [1:0] cnt_m;
    logic [1:0] cnt_w;
`endif

    exp_t q_a[$];
    exp_t q_w[$];
    logic q_m[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    seqdet_prog_mealy_moore #(.PAT_W(3), .MOORE(0), .CNT_W(2)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_we(cfg_we_a), .cfg_pattern(cfg_pattern_a), .cfg_overlap(cfg_overlap_a),
        .state(state_a), .match(match_a)
`ifdef SEQDET_MATCH_COUNT_EN
        , .match_cnt(cnt_a)
`endif
    );

    seqdet_prog_mealy_moore #(.PAT_W(3), .MOORE(1), .CNT_W(2)) dut_m (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_we(cfg_we_a), .cfg_pattern(cfg_pattern_a), .cfg_overlap(cfg_overlap_a),
        .state(state_m), .match(match_m)
`ifdef SEQDET_MATCH_COUNT_EN
        , .match_cnt(cnt_m)
`endif
    );

    seqdet_prog_mealy_moore #(.PAT_W(4), .PAT_RST(4'b0110), .OVL_RST(1'b0), .MOORE(0), .CNT_W(2)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_we(cfg_we_w), .cfg_pattern(cfg_pattern_w), .cfg_overlap(cfg_overlap_w),
        .state(state_w), .match(match_w)
`ifdef SEQDET_MATCH_COUNT_EN
        , .match_cnt(cnt_w)
`endif
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Moore output in this cycle must equal the hit expected one cycle earlier.
    task automatic chk_moore();
        if (q_m.size() > 0) begin
            chk("m_match", match_m, q_m.pop_front());
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        cfg_we_a = 1'b0;
        cfg_we_w = 1'b0;
        #2;
        chk("rst_state_a", state_a, 0);
        chk("rst_match_a", match_a, 1'b0);
        chk("rst_state_m", state_m, 0);
        chk("rst_match_m", match_m, 1'b0);
        chk("rst_state_w", state_w, 0);
        chk("rst_match_w", match_w, 1'b0);
`ifdef SEQDET_MATCH_COUNT_EN
        chk("rst_cnt_w", cnt_w, 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        q_a.delete();
        q_w.delete();
        q_m.delete();
        q_m.push_back(1'b0);
    endtask

    task automatic step_a(input logic v, input logic b, input logic em, input int es);
        exp_t e;
        in_valid = v;
        in_bit   = b;
        cfg_we_a = 1'b0;
        cfg_we_w = 1'b0;
        q_a.push_back('{em, es, 0});
        @(negedge clk);
        e = q_a[0];
        chk("a_match", match_a, e.m);
        chk_moore();
        q_m.push_back(em);
        @(posedge clk);
        #1;
        e = q_a.pop_front();
        chk("a_state", state_a, e.s);
        chk("m_state", state_m, e.s);
    endtask

    task automatic cfg_a(input logic [2:0] p, input logic o, input logic v, input logic b);
        in_valid      = v;
        in_bit        = b;
        cfg_we_a      = 1'b1;
        cfg_pattern_a = p;
        cfg_overlap_a = o;
        @(negedge clk);
        chk("a_cfg_match", match_a, 1'b0);
        chk_moore();
        q_m.push_back(1'b0);
        @(posedge clk);
        #1;
        cfg_we_a = 1'b0;
        chk("a_cfg_state", state_a, 0);
        chk("m_cfg_state", state_m, 0);
    endtask

    task automatic step_w(input logic v, input logic b, input logic em, input int es, input int ec);
        exp_t e;
        in_valid = v;
        in_bit   = b;
        cfg_we_a = 1'b0;
        cfg_we_w = 1'b0;
        q_w.push_back('{em, es, ec});
        @(negedge clk);
        e = q_w[0];
        chk("w_match", match_w, e.m);
        @(posedge clk);
        #1;
        e = q_w.pop_front();
        chk("w_state", state_w, e.s);
`ifdef SEQDET_MATCH_COUNT_EN
        chk("w_cnt", cnt_w, e.c);
`endif
    endtask

    task automatic cfg_w(input logic [3:0] p, input logic o);
        in_valid      = 1'b0;
        in_bit        = 1'b0;
        cfg_we_w      = 1'b1;
        cfg_pattern_w = p;
        cfg_overlap_w = o;
        @(negedge clk);
        chk("w_cfg_match", match_w, 1'b0);
        @(posedge clk);
        #1;
        cfg_we_w = 1'b0;
        chk("w_cfg_state", state_w, 0);
`ifdef SEQDET_MATCH_COUNT_EN
        chk("w_cfg_cnt", cnt_w, 0);
`endif
    endtask

    initial begin
        rst           = 1'b1;
        in_valid      = 1'b0;
        in_bit        = 1'b0;
        cfg_we_a      = 1'b0;
        cfg_pattern_a = 3'b000;
        cfg_overlap_a = 1'b0;
        cfg_we_w      = 1'b0;
        cfg_pattern_w = 4'b0000;
        cfg_overlap_w = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Reset defaults: 101, overlapping.
        step_a(1'b1, 1'b1, 1'b0, 1);
        step_a(1'b1, 1'b0, 1'b0, 2);
        step_a(1'b1, 1'b1, 1'b1, 1);
        step_a(1'b1, 1'b0, 1'b0, 2);
        step_a(1'b1, 1'b1, 1'b1, 1);
        step_a(1'b0, 1'b0, 1'b0, 1);

        // Non-overlapping 101.
        cfg_a(3'b101, 1'b0, 1'b0, 1'b0);
        step_a(1'b1, 1'b1, 1'b0, 1);
        step_a(1'b1, 1'b0, 1'b0, 2);
        step_a(1'b1, 1'b1, 1'b1, 0);
        step_a(1'b1, 1'b0, 1'b0, 0);
        step_a(1'b1, 1'b1, 1'b0, 1);
        step_a(1'b1, 1'b1, 1'b0, 1);
        step_a(1'b1, 1'b0, 1'b0, 2);
        step_a(1'b1, 1'b1, 1'b1, 0);
        step_a(1'b0, 1'b0, 1'b0, 0);

        // Idle gap holds progress; in_bit=1 while idle must not match.
        cfg_a(3'b101, 1'b1, 1'b0, 1'b0);
        step_a(1'b1, 1'b1, 1'b0, 1);
        step_a(1'b1, 1'b0, 1'b0, 2);
        for (int i = 0; i < 3; i++) step_a(1'b0, 1'b1, 1'b0, 2);
        step_a(1'b1, 1'b1, 1'b1, 1);

        // Reset during the gap: the next 1 is a fresh stream start.
        step_a(1'b1, 1'b1, 1'b0, 1);
        step_a(1'b1, 1'b0, 1'b0, 2);
        step_a(1'b0, 1'b1, 1'b0, 2);
        do_reset();
        step_a(1'b0, 1'b1, 1'b0, 0);
        step_a(1'b1, 1'b1, 1'b0, 1);
        step_a(1'b1, 1'b0, 1'b0, 2);
        step_a(1'b1, 1'b1, 1'b1, 1);

        // Configuration write collides with the completing bit.
        cfg_a(3'b101, 1'b1, 1'b0, 1'b0);
        step_a(1'b1, 1'b1, 1'b0, 1);
        step_a(1'b1, 1'b0, 1'b0, 2);
        cfg_a(3'b101, 1'b1, 1'b1, 1'b1);
        step_a(1'b1, 1'b1, 1'b0, 1);
        step_a(1'b1, 1'b0, 1'b0, 2);
        step_a(1'b1, 1'b1, 1'b1, 1);
        step_a(1'b0, 1'b0, 1'b0, 1);

        // 4-bit all-ones, overlapping: fallback stays at 3, counter saturates at 3.
        cfg_w(4'b1111, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step_w(1'b1, 1'b1, (i >= 3), (i < 3) ? (i + 1) : 3,
                   (i < 3) ? 0 : (((i - 2) > 3) ? 3 : (i - 2)));
        end

        // 4-bit all-ones, non-overlapping.
        cfg_w(4'b1111, 1'b0);
        step_w(1'b1, 1'b1, 1'b0, 1, 0);
        step_w(1'b1, 1'b1, 1'b0, 2, 0);
        step_w(1'b1, 1'b1, 1'b0, 3, 0);
        step_w(1'b1, 1'b1, 1'b1, 0, 1);
        step_w(1'b1, 1'b1, 1'b0, 1, 1);

        // 4-bit 1001, overlapping: the trailing 1 seeds the next match.
        cfg_w(4'b1001, 1'b1);
        step_w(1'b1, 1'b1, 1'b0, 1, 0);
        step_w(1'b1, 1'b0, 1'b0, 2, 0);
        step_w(1'b1, 1'b0, 1'b0, 3, 0);
        step_w(1'b1, 1'b1, 1'b1, 1, 1);
        step_w(1'b1, 1'b0, 1'b0, 2, 1);
        step_w(1'b1, 1'b0, 1'b0, 3, 1);
        step_w(1'b1, 1'b1, 1'b1, 1, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seqdet_prog_mealy_moore.md
Name: seqdet_prog_mealy_moore

Overview:
Parametrised, runtime-programmable serial sequence detector. It is the successor of the fixed 3-bit "101" overlapping Mealy detector. It generalises pattern width, makes the pattern and overlap mode runtime-configurable, adds an input-valid qualifier and a compile-time Mealy/Moore output selection. It sits on a serial bit stream inside the FSM examples library.

Parameters:
PAT_W, 3, pattern length in bits (2..16)
PAT_RST, 3'b101, pattern loaded at reset; bit PAT_W-1 is the first bit expected
OVL_RST, 1, overlap mode at reset (1 = overlapping, 0 = non-overlapping)
MOORE, 0, 0 = Mealy output (combinational), 1 = Moore output (registered)
CNT_W, 8, match counter width (used only with optional feature)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  in_bit is consumed this cycle
in_bit  in  1  serial data bit
cfg_we  in  1  load cfg_pattern/cfg_overlap this cycle
cfg_pattern  in  PAT_W  new pattern
cfg_overlap  in  1  new overlap mode
state  out  SW=$clog2(PAT_W+1)  current progress: matched prefix length 0..PAT_W-1
match  out  1  pattern detected
match_cnt  out  CNT_W  total matches (only with SEQDET_MATCH_COUNT_EN)

Behaviour:
- Reset (async, rst=1): state=0, match=0, match_cnt=0, pattern_q=PAT_RST, ovl_q=OVL_RST, history cleared, fill=0.
- Internal regs: pattern_q, ovl_q, hist (PAT_W-1 most recent accepted bits), fill (number of valid bits in hist, saturating at PAT_W-1).
- Candidate stream S = valid history bits followed by in_bit. For k from min(state+1,PAT_W) down to 0, nxt = the largest k for which the last k bits of S equal pattern_q[PAT_W-1 -: k]. k=0 always satisfies.
- hit = in_valid & ~cfg_we & (nxt==PAT_W).
- On in_valid & ~cfg_we:
  - shift in_bit into hist; fill++.
  - No hit: state<=nxt.
  - Hit, ovl_q=1: state <= the largest k<PAT_W satisfying the same suffix/prefix condition. This is overlap fallback.
  - Hit, ovl_q=0: state<=0, fill<=0. Bits before and including the match cannot seed the next match.
- in_valid=0: all state held. A Mealy match is 0.
- cfg_we (takes priority over in_valid; the concurrent bit is discarded): pattern_q<=cfg_pattern, ovl_q<=cfg_overlap, state<=0, fill<=0. No match that cycle or next.
- Output timing:
  - MOORE=0: match=hit, combinational, in the same cycle as the final bit.
  - MOORE=1: match_q<=hit, so match is high for exactly the one cycle after the final bit. It clears on the next edge unless hit repeats.
- Back-to-back hits on consecutive cycles are legal. This can happen in overlap mode, e.g. pattern 11: every 1 after the first.
- Pattern of all-identical bits, overlap: fallback state = PAT_W-1.
- Reset mid-stream: immediate clear. The first post-reset bit is treated as stream start.

Optional Feature:
SEQDET_MATCH_COUNT_EN.
- Defined: match_cnt increments on every hit, saturating at 2^CNT_W-1. It is cleared by rst and by cfg_we. It is independent of MOORE; it counts on the hit cycle.
- Undefined: the match_cnt port is absent and no counter logic is generated.

Decomposition:
- Package seqdet_pkg holds:
  - the state-width function (clog2 of PAT_W+1);
  - localparams for the output modes MEALY=0 and MOORE=1;
  - the default pattern constant.
- One natural sub-module, seqdet_prefix_match: a purely combinational block that takes hist, fill, in_bit, pattern_q and state, and returns nxt and the overlap fallback length.

Test Plan:
- Reset defaults (101, overlap, Mealy), in_valid=1, bits 1,0,1,0,1 -> match high on the 3rd and 5th bits; state sequence 1,2,1,2,1.
- cfg_we with 101, overlap=0, bits 1,0,1,0,1,1,0,1 -> match on the 3rd and 8th bits only; state=0 after each hit.
- MOORE=1, same stream as the first scenario -> match high in the cycle after the 3rd and 5th bits, one cycle wide each.
- PAT_W=4, cfg pattern 1111, overlap=1, six 1s -> match on bits 4, 5 and 6; state holds 3 after the first hit.
- Bits 1,0 then in_valid=0 for 3 cycles then 1 -> state holds 2 through the gap, then match on resumption. rst pulsed mid-gap instead -> state=0 and no match on the 1.
- cfg_we asserted together with the final bit of a pending match -> no match, state=0. With SEQDET_MATCH_COUNT_EN and CNT_W=2, five hits -> match_cnt saturates at 3.
